alu_arbiter: RTL and testbench

Shares one `ALU` instance between `N_REQ` requesters, such as the main execute path, a branch-compare unit and a debug/test port. It is the only block that drives the `ALU` inputs.

- Requesters use a valid/ready handshake; a round-robin arbiter picks one per cycle.
- The ALU output is registered into a single response slot, tagged with the requester ID.
- The slot is drained through its own valid/ready handshake.

---
 rtl/ALU_pkg.sv | 24 ++
 rtl/ALU.sv | 32 +++
 rtl/rr_arbiter.sv | 20 ++
 rtl/alu_arbiter.sv | 63 ++++++
 tb/tb_alu_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ALU_pkg.sv
// ALU_pkg: ALU control codes and the operation bundle shared by ALU requesters
package ALU_pkg;
  localparam int ALU_OP_W = 6;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 6'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 6'd9;
  localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 6'd10;
  localparam logic [ALU_OP_W-1:0] ALU_BNE  = 6'd11;
  localparam logic [ALU_OP_W-1:0] ALU_BLT  = 6'd12;
  localparam logic [ALU_OP_W-1:0] ALU_BGE  = 6'd13;
  localparam logic [ALU_OP_W-1:0] ALU_BLTU = 6'd14;
  typedef struct packed {
    logic [31:0]         a;
    logic [31:0]         b;
    logic [ALU_OP_W-1:0] op;
  } alu_req_t;
endpackage

// File: rtl/ALU.sv
// ALU: combinational 32-bit ALU; branch ops return 1 when the condition holds
import ALU_pkg::*;
module ALU (
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  input  logic [ALU_OP_W-1:0] ALUcontrol,
  output logic [31:0]         result,
  output logic                zero
);
  always_comb begin
    result = '0;
    case (ALUcontrol)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $signed(a) >>> b[4:0];
      ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: result = {31'b0, a < b};
      ALU_BEQ:  result = {31'b0, a == b};
      ALU_BNE:  result = {31'b0, a != b};
      ALU_BLT:  result = {31'b0, $signed(a) < $signed(b)};
      ALU_BGE:  result = {31'b0, $signed(a) >= $signed(b)};
      ALU_BLTU: result = {31'b0, a < b};
      default:  result = '0;
    endcase
  end
  assign zero = result == '0;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin, search starts just after the last winner
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant
);
  localparam logic [N-1:0] ONE = 1;
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(last) + k) % N);
      if (req[j]) grant = ONE << j;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among N_REQ requesters with a registered, tagged response slot
import ALU_pkg::*;
module alu_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req_valid,
  output logic [N_REQ-1:0]                   req_ready,
  input  logic [N_REQ-1:0][31:0]             req_a,
  input  logic [N_REQ-1:0][31:0]             req_b,
  input  logic [N_REQ-1:0][ALU_OP_W-1:0]     req_op,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [ID_W-1:0]                    rsp_id,
  output logic [31:0]                        rsp_result,
  output logic                               rsp_zero
);
  localparam logic [ID_W-1:0] LAST_INIT = ID_W'(N_REQ - 1);
  logic [ID_W-1:0]  last_grant, gidx;
  logic [N_REQ-1:0] grant;
  logic             free, accept, alu_zero;
  logic [31:0]      alu_result;
  rr_arbiter #(.N(N_REQ), .W(ID_W)) u_rr (
    .req   (req_valid),
    .last  (last_grant),
    .grant (grant)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = i[ID_W-1:0];
  end
  assign free      = !rsp_valid | rsp_ready;
  assign req_ready = rst ? '0 : grant & {N_REQ{free}};
  assign accept    = |(req_valid & req_ready);
  // with no grant gidx is 0, so the idle ALU sees requester 0
  ALU u_alu (
    .a          (req_a[gidx]),
    .b          (req_b[gidx]),
    .ALUcontrol (req_op[gidx]),
    .result     (alu_result),
    .zero       (alu_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
      last_grant <= LAST_INIT;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= gidx;
      last_grant <= gidx;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic against a behavioural model
import ALU_pkg::*;
module tb_alu_arbiter;
  localparam int N = 3;
  localparam int W = 2;
  logic                 clk = 0, rst = 1, rsp_ready = 1;
  logic [N-1:0]         req_valid = '1, req_ready, acc;
  logic [N-1:0][31:0]   req_a = '0, req_b = '0;
  logic [N-1:0][5:0]    req_op = '0;
  logic                 rsp_valid, rsp_zero;
  logic [W-1:0]         rsp_id;
  logic [31:0]          rsp_result;
  int checks = 0, errors = 0;
  bit armed = 0;
  bit m_valid = 0, m_zero = 0;
  int m_id = 0, m_last = N - 1, w;
  logic [31:0] m_res = 0;
  logic [N-1:0] er;
  logic [31:0] hold_res;
  logic [W-1:0] hold_id;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] am(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa = a, sb = b;
    int unsigned sh = b % 32;
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << sh;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return sa >>> sh;
      ALU_SLT, ALU_BLT: return (sa < sb) ? 1 : 0;
      ALU_SLTU, ALU_BLTU: return (a < b) ? 1 : 0;
      ALU_BEQ:  return (a == b) ? 1 : 0;
      ALU_BNE:  return (a != b) ? 1 : 0;
      ALU_BGE:  return (sa >= sb) ? 1 : 0;
      default:  return 0;
    endcase
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  initial begin
    @(posedge clk);
    armed = 1;
  end

  always @(negedge clk) if (armed) begin
    w = rst ? -1 : winner(req_valid, m_last);
    er = '0;
    if (w >= 0 && (!m_valid || rsp_ready)) er[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), m_id);
    chk("rsp_result", rsp_result, m_res);
    chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
    if (rst) begin
      m_valid = 0; m_id = 0; m_res = 0; m_zero = 0; m_last = N - 1;
    end else if (er != 0) begin
      m_valid = 1; m_id = w; m_last = w;
      m_res = am(req_op[w], req_a[w], req_b[w]);
      m_zero = (m_res == 0);
    end else if (rsp_ready) m_valid = 0;
  end

  initial begin
    tick();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    chk("rst_result", rsp_result, 0);
    chk("rst_id", 32'(rsp_id), 0);
    tick();
    rst = 0;
    req_op[0] = ALU_ADD; req_a[0] = 1; req_b[0] = 1;
    @(negedge clk);
    chk("first_grant", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 0);
    chk("single_result", rsp_result, 2);
    chk("single_zero", 32'(rsp_zero), 0);
    tick();
    req_valid = 3'b011;
    req_op[0] = ALU_SUB; req_a[0] = 5; req_b[0] = 5;
    req_op[1] = ALU_ADD; req_a[1] = 3; req_b[1] = 4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("fair_id", 32'(rsp_id), k % 2);
        chk("fair_result", rsp_result, (k % 2) ? 7 : 0);
        chk("fair_zero", 32'(rsp_zero), (k % 2) ? 0 : 1);
      end
      tick();
    end
    rsp_ready = 0;
    req_valid = 3'b010;
    req_op[1] = ALU_SLT; req_a[1] = 32'hFFFF_FFFF; req_b[1] = 2;
    @(negedge clk);
    hold_res = rsp_result; hold_id = rsp_id;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 32'(hold_id));
      chk("bp_result", rsp_result, hold_res);
      tick();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("bp_rsp_id", 32'(rsp_id), 1);
    chk("bp_rsp_result", rsp_result, 1);
    tick();
    @(negedge clk);
    chk("drained", 32'(rsp_valid), 0);
    tick();
    req_valid = 3'b001;
    req_op[0] = ALU_SLL; req_a[0] = 1; req_b[0] = 2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("stream_valid", 32'(rsp_valid), 1);
        chk("stream_result", rsp_result, 4);
      end
      tick();
    end
    rsp_ready = 0;
    req_valid = '0;
    @(negedge clk);
    chk("pre_rst_full", 32'(rsp_valid), 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 0);
    tick();
    rst = 0; rsp_ready = 1; req_valid = 3'b011;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_grant", 32'(req_ready), 32'b001);
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      rst = ($urandom_range(0, 99) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = $urandom_range(0, 1);
          req_a[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 4);
          req_b[i] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 4);
          req_op[i] = 6'($urandom_range(0, 15));
        end
    end
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
